// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline hazard control for a 5-stage in-order core.
//   * EX-stage operand forwarding selects (combinational, M beats W).
//   * Load-use detection: stalls F/D and bubbles ID/EX for one cycle.
//   * Branch/jump redirect: flushes IF/ID and ID/EX.
//   * Multi-cycle mul/div occupancy of EX via a small IDLE/BUSY FSM that
//     holds the front of the pipe for MULDIV_LATENCY-1 cycles.
// Optional build macro HAZARD_PERF_EN adds three 32-bit performance counters.
// i_rst is asynchronous and active-low; while low, every output reads 0.
module hazard_unit #(
  parameter int REG_WIDTH      = 5,
  parameter int MULDIV_LATENCY = 4   // legal range 1..16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [REG_WIDTH-1:0] i_rs1_d,
  input  logic [REG_WIDTH-1:0] i_rs2_d,
  input  logic [REG_WIDTH-1:0] i_rs1_e,
  input  logic [REG_WIDTH-1:0] i_rs2_e,
  input  logic [REG_WIDTH-1:0] i_rd_e,
  input  logic [REG_WIDTH-1:0] i_rd_m,
  input  logic [REG_WIDTH-1:0] i_rd_w,
  input  logic [1:0]           i_result_src_e,
  input  logic                 i_reg_write_m,
  input  logic                 i_reg_write_w,
  input  logic                 i_pc_src_e,
  input  logic                 i_muldiv_e,
  output logic                 o_stall_f,
  output logic                 o_stall_d,
  output logic                 o_flush_d,
  output logic                 o_stall_e,
  output logic                 o_flush_e,
  output logic                 o_flush_m,
  output logic [1:0]           o_forward_a_e,
  output logic [1:0]           o_forward_b_e,
`ifdef HAZARD_PERF_EN
  output logic [31:0]          o_perf_stall_cycles,
  output logic [31:0]          o_perf_flushes,
  output logic [31:0]          o_perf_lu_stalls,
`endif
  output logic                 o_busy
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  // A latency of 1 means the op finishes in its own EX cycle: no FSM use.
  localparam logic       MD_MULTI    = (MULDIV_LATENCY > 1);
  // Remaining BUSY hold cycles after the combinational first stall.
  localparam logic [3:0] COUNT_START = 4'((MULDIV_LATENCY > 1) ? (MULDIV_LATENCY - 2) : 0);

  localparam logic [REG_WIDTH-1:0] ZERO_REG = '0;

  logic       r_state;
  logic [3:0] r_count;
  logic       w_state_nxt;
  logic [3:0] w_count_nxt;

  logic       w_lw_hz;
  logic       w_md_hz;
  logic       w_lu_stall;
  logic       w_stall_f;
  logic       w_flush_d;
  logic       w_stall_e;
  logic       w_flush_e;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Forwarding selects: newest producer (M) wins over W; x0 never forwards.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (i_reg_write_m && (i_rd_m != ZERO_REG) && (i_rd_m == i_rs1_e))
      w_fwd_a = 2'b10;
    else if (i_reg_write_w && (i_rd_w != ZERO_REG) && (i_rd_w == i_rs1_e))
      w_fwd_a = 2'b01;
    if (i_reg_write_m && (i_rd_m != ZERO_REG) && (i_rd_m == i_rs2_e))
      w_fwd_b = 2'b10;
    else if (i_reg_write_w && (i_rd_w != ZERO_REG) && (i_rd_w == i_rs2_e))
      w_fwd_b = 2'b01;
  end

  assign w_lw_hz = (i_result_src_e == 2'b01) && (i_rd_e != ZERO_REG) &&
                   ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
  assign w_md_hz = i_muldiv_e && MD_MULTI;

  // FSM next state and stall/flush decode; BUSY ignores redirects and load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_stall_f   = 1'b0;
    w_flush_d   = 1'b0;
    w_stall_e   = 1'b0;
    w_flush_e   = 1'b0;
    w_lu_stall  = 1'b0;
    if (r_state == S_IDLE) begin
      w_stall_f  = w_lw_hz || w_md_hz;
      w_stall_e  = w_md_hz;
      w_flush_e  = w_lw_hz || i_pc_src_e;
      w_flush_d  = i_pc_src_e;
      w_lu_stall = w_lw_hz;
      if (w_md_hz) begin
        w_state_nxt = S_BUSY;
        w_count_nxt = COUNT_START;
      end
    end else begin
      w_stall_f = (r_count != 4'd0);
      w_stall_e = (r_count != 4'd0);
      if (r_count != 4'd0)
        w_count_nxt = r_count - 4'd1;
      else
        w_state_nxt = S_IDLE;   // EX op completes and advances this cycle
    end
  end

  // State and countdown registers; async reset drops any pending mul/div hold.
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Outputs are forced low while reset is held, independent of any clock edge.
  assign o_stall_f     = i_rst & w_stall_f;
  assign o_stall_d     = i_rst & w_stall_f;
  assign o_flush_d     = i_rst & w_flush_d;
  assign o_stall_e     = i_rst & w_stall_e;
  assign o_flush_e     = i_rst & w_flush_e;
  assign o_flush_m     = i_rst & w_stall_e;
  assign o_forward_a_e = i_rst ? w_fwd_a : 2'b00;
  assign o_forward_b_e = i_rst ? w_fwd_b : 2'b00;
  assign o_busy        = i_rst & (r_state == S_BUSY);

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall_cycles;
  logic [31:0] r_perf_flushes;
  logic [31:0] r_perf_lu_stalls;

  // Free-running event counters; wrap modulo 2^32.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_perf_stall_cycles <= 32'd0;
      r_perf_flushes      <= 32'd0;
      r_perf_lu_stalls    <= 32'd0;
    end else begin
      if (w_stall_f)  r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      if (w_flush_d)  r_perf_flushes      <= r_perf_flushes + 32'd1;
      if (w_lu_stall) r_perf_lu_stalls    <= r_perf_lu_stalls + 32'd1;
    end
  end

  assign o_perf_stall_cycles = r_perf_stall_cycles;
  assign o_perf_flushes      = r_perf_flushes;
  assign o_perf_lu_stalls    = r_perf_lu_stalls;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit -- directed table-driven checks of hazard_unit plus
// hand-written mul/div, back-to-back and reset-in-BUSY sequences.
// Counter checks are included when HAZARD_PERF_EN is defined.
module tb_hazard_unit;

  logic       i_clk;
  logic       i_rst;
  logic [4:0] i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w;
  logic [1:0] i_result_src_e;
  logic       i_reg_write_m, i_reg_write_w, i_pc_src_e, i_muldiv_e;
  logic       o_stall_f, o_stall_d, o_flush_d, o_stall_e, o_flush_e, o_flush_m, o_busy;
  logic [1:0] o_forward_a_e, o_forward_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] o_perf_stall_cycles, o_perf_flushes, o_perf_lu_stalls;
`endif

  hazard_unit #(.REG_WIDTH(5), .MULDIV_LATENCY(4)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_rs1_d        (i_rs1_d),
    .i_rs2_d        (i_rs2_d),
    .i_rs1_e        (i_rs1_e),
    .i_rs2_e        (i_rs2_e),
    .i_rd_e         (i_rd_e),
    .i_rd_m         (i_rd_m),
    .i_rd_w         (i_rd_w),
    .i_result_src_e (i_result_src_e),
    .i_reg_write_m  (i_reg_write_m),
    .i_reg_write_w  (i_reg_write_w),
    .i_pc_src_e     (i_pc_src_e),
    .i_muldiv_e     (i_muldiv_e),
    .o_stall_f      (o_stall_f),
    .o_stall_d      (o_stall_d),
    .o_flush_d      (o_flush_d),
    .o_stall_e      (o_stall_e),
    .o_flush_e      (o_flush_e),
    .o_flush_m      (o_flush_m),
    .o_forward_a_e  (o_forward_a_e),
    .o_forward_b_e  (o_forward_b_e),
`ifdef HAZARD_PERF_EN
    .o_perf_stall_cycles (o_perf_stall_cycles),
    .o_perf_flushes      (o_perf_flushes),
    .o_perf_lu_stalls    (o_perf_lu_stalls),
`endif
    .o_busy         (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Control outputs bundled: {stall_f, stall_d, flush_d, stall_e, flush_e, flush_m, busy}
  logic [6:0] w_ctl;
  assign w_ctl = {o_stall_f, o_stall_d, o_flush_d, o_stall_e, o_flush_e, o_flush_m, o_busy};

  localparam logic [6:0] C_NONE    = 7'b0000000;
  localparam logic [6:0] C_LU      = 7'b1100100;
  localparam logic [6:0] C_BR      = 7'b0010100;
  localparam logic [6:0] C_BR_LU   = 7'b1110100;
  localparam logic [6:0] C_MD_IDLE = 7'b1101010;
  localparam logic [6:0] C_MD_HOLD = 7'b1101011;
  localparam logic [6:0] C_MD_LAST = 7'b0000001;

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] rsrc;
    logic       rwm, rww, pc;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_rs1_d = 0; i_rs2_d = 0; i_rs1_e = 0; i_rs2_e = 0;
    i_rd_e = 0; i_rd_m = 0; i_rd_w = 0; i_result_src_e = 2'b00;
    i_reg_write_m = 0; i_reg_write_w = 0; i_pc_src_e = 0; i_muldiv_e = 0;
  endtask

  task automatic apply(input vec_t v);
    i_rs1_d = v.rs1_d; i_rs2_d = v.rs2_d; i_rs1_e = v.rs1_e; i_rs2_e = v.rs2_e;
    i_rd_e = v.rd_e; i_rd_m = v.rd_m; i_rd_w = v.rd_w; i_result_src_e = v.rsrc;
    i_reg_write_m = v.rwm; i_reg_write_w = v.rww; i_pc_src_e = v.pc; i_muldiv_e = 1'b0;
  endtask

  // Sets up a load-use hazard on rs2 (rd_e = 7) that BUSY must ignore.
  task automatic drive_ignored_hazards();
    i_result_src_e = 2'b01; i_rd_e = 5'd7; i_rs2_d = 5'd7; i_pc_src_e = 1'b1;
  endtask

  vec_t vecs[14];

  initial begin
    // rs1_d rs2_d rs1_e rs2_e rd_e rd_m rd_w rsrc rwm rww pc   fa    fb    ctl
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, C_NONE};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, C_NONE};
    vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd3, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, C_NONE};
    vecs[5]  = '{5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 5'd6, 5'd6, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, C_NONE};
    vecs[6]  = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd4, 5'd4, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[7]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_LU};
    vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_LU};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[10] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[11] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, C_BR};
    vecs[13] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, C_BR_LU};

    // Reset state: outputs held low even with hazardous inputs driven.
    clear_inputs();
    i_rst = 1'b0;
    i_rs1_e = 5'd5; i_rd_m = 5'd5; i_reg_write_m = 1'b1; i_pc_src_e = 1'b1; i_muldiv_e = 1'b1;
    #1;
    check("reset_ctl", 32'(w_ctl), 32'(C_NONE));
    check("reset_fwd_a", 32'(o_forward_a_e), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    clear_inputs();
    i_rst = 1'b1;
    #1;
    check("post_reset_ctl", 32'(w_ctl), 32'(C_NONE));

    // Combinational vectors, all in IDLE.
    for (int i = 0; i < 14; i++) begin
      @(negedge i_clk);
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_fwd_a", i), 32'(o_forward_a_e), 32'(vecs[i].fa));
      check($sformatf("vec%0d_fwd_b", i), 32'(o_forward_b_e), 32'(vecs[i].fb));
      check($sformatf("vec%0d_ctl", i),   32'(w_ctl),         32'(vecs[i].ctl));
    end

    // Two back-to-back mul/div ops, each giving exactly 3 stall cycles.
    for (int op = 0; op < 2; op++) begin
      @(negedge i_clk);
      clear_inputs();
      i_muldiv_e = 1'b1;
      #1;
      check($sformatf("md%0d_c1_idle", op), 32'(w_ctl), 32'(C_MD_IDLE));
      for (int c = 2; c <= 3; c++) begin
        @(negedge i_clk);
        drive_ignored_hazards();
        #1;
        check($sformatf("md%0d_c%0d_hold", op, c), 32'(w_ctl), 32'(C_MD_HOLD));
      end
      @(negedge i_clk);
      #1;
      check($sformatf("md%0d_c4_last", op), 32'(w_ctl), 32'(C_MD_LAST));
    end
    @(negedge i_clk);
    clear_inputs();
    #1;
    check("md_back_to_idle", 32'(w_ctl), 32'(C_NONE));

    // Reset asserted in BUSY with count=1: outputs drop without a clock edge.
    @(negedge i_clk);
    i_muldiv_e = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rs1_e = 5'd5; i_rd_m = 5'd5; i_reg_write_m = 1'b1;
    #1;
    check("rst_pre_hold", 32'(w_ctl), 32'(C_MD_HOLD));
    i_rst = 1'b0;
    #1;
    check("rst_async_ctl", 32'(w_ctl), 32'(C_NONE));
    check("rst_async_fwd", 32'(o_forward_a_e), 32'd0);
    @(negedge i_clk);
    clear_inputs();
    i_rst = 1'b1;
    #1;
    check("rst_release_ctl", 32'(w_ctl), 32'(C_NONE));
    @(negedge i_clk);
    #1;
    check("rst_no_residual", 32'(w_ctl), 32'(C_NONE));

`ifdef HAZARD_PERF_EN
    // Fresh counters: one mul/div (3 stalls) then one load-use (1 stall).
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("perf_reset_stall", o_perf_stall_cycles, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_muldiv_e = 1'b1;
    @(negedge i_clk);
    clear_inputs();
    @(negedge i_clk);
    @(negedge i_clk);
    @(negedge i_clk);
    i_result_src_e = 2'b01; i_rd_e = 5'd7; i_rs2_d = 5'd7;
    @(negedge i_clk);
    clear_inputs();
    #1;
    check("perf_stall_cycles", o_perf_stall_cycles, 32'd4);
    check("perf_lu_stalls",    o_perf_lu_stalls,    32'd1);
    check("perf_flushes",      o_perf_flushes,      32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
